updi_frame_sequencer: RTL and testbench
=======================================

Name: updi_frame_sequencer

Overview:
Parametrised successor to the UPDI TX path. Emits one complete UPDI frame (SYNC, opcode, data bytes) into the UART TX FIFO, optionally consumes and checks the single-wire echo of every byte, and waits for ACKs after flagged data bytes. Adds per-wait timeout and whole-frame retry. Sits between instruction conversion and the UART FIFOs.

Parameters:
MAX_DATA_SIZE, 64, maximum data bytes per frame
DATA_ADDR_BITS, $clog2(MAX_DATA_SIZE), data index width
ACK_TIMEOUT_CYCLES, 4096, cycles allowed for each echo/ACK byte to arrive (>=2)
MAX_RETRIES, 2, whole-frame resends after an ACK failure (0 = no retry)
ECHO_DISCARD, 1, 1 = read back and compare the echo of every transmitted byte
SYNC_BYTE, 8'h55, first byte of every frame
ACK_BYTE, 8'h40, expected ACK value

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-low
opcode  in  8  UPDI opcode byte
data  in  8 x MAX_DATA_SIZE  payload, data[0] sent first
data_len  in  DATA_ADDR_BITS+1  payload byte count, 0..MAX_DATA_SIZE
wait_ack_after  in  MAX_DATA_SIZE  bit k set = wait for ACK after data[k]
tx_start  in  1  start request, accepted only when tx_ready
tx_ready  out  1  idle, inputs may change
tx_done  out  1  one-cycle pulse at frame end (success or failure)
ack_error  out  1  sticky: wrong ACK value on final attempt
timeout_error  out  1  sticky: echo/ACK timeout on final attempt
echo_error  out  1  sticky: echo mismatch
retry_count  out  $clog2(MAX_RETRIES+1)  retries used by the last frame
uart_tx_fifo_data  out  8  byte to TX FIFO
uart_tx_fifo_wr_en  out  1  TX FIFO write strobe
uart_tx_fifo_full  in  1  TX FIFO full
uart_rx_fifo_data  in  8  RX FIFO head; valid the cycle after rd_en
uart_rx_fifo_rd_en  out  1  RX FIFO read strobe
uart_rx_fifo_empty  in  1  RX FIFO empty

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; tx_ready=1; tx_done, all error flags, retry_count, wr_en, rd_en = 0; uart_tx_fifo_data=0. Reset mid-frame aborts at once, no further FIFO writes.
- IDLE: tx_start && tx_ready latches opcode, data, data_len, wait_ack_after; clears error flags and retry_count; tx_ready drops next cycle. tx_start while busy ignored.
- Byte index b: b=0 SYNC_BYTE, b=1 opcode, b=2..data_len+1 data[b-2]. data_len=0 sends SYNC+opcode only; data_len>MAX_DATA_SIZE clamped to MAX_DATA_SIZE.
- SEND: if !uart_tx_fifo_full, wr_en=1 for one cycle with byte b; else hold, no write, no byte skipped. With ECHO_DISCARD=0 and no ACK pending, back-to-back bytes one per cycle.
- ECHO_WAIT (ECHO_DISCARD=1): wait for !empty, pulse rd_en one cycle, compare data next cycle (ECHO_CHK). Mismatch -> echo_error=1, go FAIL (no retry: bus collision).
- ACK_WAIT: entered after data byte k (and its echo) when wait_ack_after[k]=1; pop one byte as above (ACK_CHK). ==ACK_BYTE -> continue at b+1; else -> attempt failed (wrong value).
- Timeout counter: cleared on entering ECHO_WAIT/ACK_WAIT, increments each waiting cycle; reaching ACK_TIMEOUT_CYCLES = attempt failed (timeout).
- Attempt failed: if retry_count<MAX_RETRIES, retry_count++, restart at b=0 (SYNC resent); else set ack_error or timeout_error per cause, go FAIL.
- After last byte (and its echo/ACK): DONE -> tx_done=1 one cycle -> IDLE, tx_ready=1 same cycle as tx_done. FAIL behaves identically with flag set.
- Never more than one rd_en outstanding; never rd_en while empty; never wr_en while full.
- Flags hold until next accepted tx_start or reset.

Test Plan:
- ECHO_DISCARD=0, opcode 8'h45, data 12 34 56 78, len 4, ACK after bits 1,3; push 8'h40 twice -> TX FIFO 55 45 12 34 56 78; tx_ready low until second ACK; tx_done one pulse; no flags.
- ECHO_DISCARD=0, ACK_TIMEOUT_CYCLES=16, MAX_RETRIES=1, len 2 data 12 34, ACK after bit 1, no ACK -> TX FIFO 55 45 12 34 55 45 12 34; timeout_error=1, retry_count=1, tx_done pulse.
- Same config, push 8'h00 then 8'h40 -> first attempt fails, second succeeds; no flags, retry_count=1, eight bytes written.
- ECHO_DISCARD=1, TX looped into RX FIFO, opcode 8'h04, len 0 -> 55 04 written, both echoes consumed, RX FIFO empty, success; corrupt opcode echo to 8'h05 -> echo_error=1, no retry.
- Hold uart_tx_fifo_full=1 for 5 cycles mid-frame -> no wr_en while full, sequence intact afterward.
- Assert rst=0 after 3 bytes sent -> next cycle tx_ready=1, all outputs at reset values, no further writes.

Source files
------------

// File: rtl/updi_frame_sequencer_if.sv
// Frame-request and UART FIFO signals between instruction conversion, the
// UPDI frame sequencer and the UART TX/RX FIFOs.
interface updi_frame_sequencer_if #(
  parameter int MAX_DATA_SIZE  = 64,
  parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int MAX_RETRIES    = 2
);
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic [7:0]                    opcode;
  logic [MAX_DATA_SIZE-1:0][7:0] data;
  logic [DATA_ADDR_BITS:0]       data_len;
  logic [MAX_DATA_SIZE-1:0]      wait_ack_after;
  logic                          tx_start;
  logic                          tx_ready;
  logic                          tx_done;
  logic                          ack_error;
  logic                          timeout_error;
  logic                          echo_error;
  logic [RC_W-1:0]               retry_count;
  logic [7:0]                    uart_tx_fifo_data;
  logic                          uart_tx_fifo_wr_en;
  logic                          uart_tx_fifo_full;
  logic [7:0]                    uart_rx_fifo_data;
  logic                          uart_rx_fifo_rd_en;
  logic                          uart_rx_fifo_empty;

  // master = the sequencer, slave = requester plus FIFOs
  modport master (
    input  opcode, data, data_len, wait_ack_after, tx_start,
           uart_tx_fifo_full, uart_rx_fifo_data, uart_rx_fifo_empty,
    output tx_ready, tx_done, ack_error, timeout_error, echo_error, retry_count,
           uart_tx_fifo_data, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en
  );
  modport slave (
    output opcode, data, data_len, wait_ack_after, tx_start,
           uart_tx_fifo_full, uart_rx_fifo_data, uart_rx_fifo_empty,
    input  tx_ready, tx_done, ack_error, timeout_error, echo_error, retry_count,
           uart_tx_fifo_data, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en
  );
endinterface

// File: rtl/updi_frame_sequencer.sv
// Emits one UPDI frame (SYNC, opcode, payload) into the UART TX FIFO, checks
// single-wire echoes, waits for ACKs, with per-wait timeout and frame retry.
module updi_frame_sequencer #(
  parameter int         MAX_DATA_SIZE      = 64,
  parameter int         DATA_ADDR_BITS     = $clog2(MAX_DATA_SIZE),
  parameter int         ACK_TIMEOUT_CYCLES = 4096,
  parameter int         MAX_RETRIES        = 2,
  parameter bit         ECHO_DISCARD       = 1'b1,
  parameter logic [7:0] SYNC_BYTE          = 8'h55,
  parameter logic [7:0] ACK_BYTE           = 8'h40
) (
  input logic                    clk,
  input logic                    rst,
  updi_frame_sequencer_if.master bus
);
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int LW   = DATA_ADDR_BITS + 1;
  localparam int BW   = DATA_ADDR_BITS + 2;
  localparam int TW   = $clog2(ACK_TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] MAX_LEN = LW'(MAX_DATA_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_ECHO_WAIT, S_ECHO_CHK, S_ACK_WAIT, S_ACK_CHK, S_DONE, S_FAIL
  } state_t;

  state_t state, state_d, after_byte, retry_or_fail;

  logic [7:0]                    op_q;
  logic [MAX_DATA_SIZE-1:0][7:0] data_q;
  logic [LW-1:0]                 len_q;
  logic [MAX_DATA_SIZE-1:0]      wack_q;
  logic [BW-1:0]                 b;
  logic [TW-1:0]                 tmo_cnt;
  logic [RC_W-1:0]               retry_q;
  logic                          ack_err_q, tmo_err_q, echo_err_q, done_q;

  logic [DATA_ADDR_BITS-1:0] didx;
  logic [7:0]                cur_byte;
  logic in_wait, last_b, ack_here, tmo_hit, can_retry;
  logic echo_bad, ack_ok, attempt_fail, advance;

  // b = 0 SYNC, 1 opcode, 2.. payload
  assign didx      = DATA_ADDR_BITS'(b - BW'(2));
  assign cur_byte  = (b == '0) ? SYNC_BYTE : (b == BW'(1)) ? op_q : data_q[didx];
  assign last_b    = (b == BW'(len_q) + BW'(1));
  assign ack_here  = (b >= BW'(2)) && wack_q[didx];
  assign in_wait   = (state == S_ECHO_WAIT) || (state == S_ACK_WAIT);
  assign tmo_hit   = (tmo_cnt == TW'(ACK_TIMEOUT_CYCLES - 1));
  assign can_retry = (retry_q < RC_W'(MAX_RETRIES));
  assign echo_bad  = (bus.uart_rx_fifo_data != cur_byte);
  assign ack_ok    = (bus.uart_rx_fifo_data == ACK_BYTE);

  assign attempt_fail = (in_wait && bus.uart_rx_fifo_empty && tmo_hit) ||
                        ((state == S_ACK_CHK) && !ack_ok);

  assign advance = !attempt_fail && (state_d == S_SEND) &&
                   (((state == S_SEND) && !bus.uart_tx_fifo_full) ||
                    (state == S_ECHO_CHK) || (state == S_ACK_CHK));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    after_byte    = ack_here ? S_ACK_WAIT : (last_b ? S_DONE : S_SEND);
    retry_or_fail = can_retry ? S_SEND : S_FAIL;
    state_d       = state;
    case (state)
      S_IDLE:      if (bus.tx_start) state_d = S_SEND;
      S_SEND:      if (!bus.uart_tx_fifo_full)
                     state_d = ECHO_DISCARD ? S_ECHO_WAIT : after_byte;
      S_ECHO_WAIT: if (!bus.uart_rx_fifo_empty) state_d = S_ECHO_CHK;
                   else if (tmo_hit)            state_d = retry_or_fail;
      // a wrong echo means a bus collision, so resending would not help
      S_ECHO_CHK:  state_d = echo_bad ? S_FAIL : after_byte;
      S_ACK_WAIT:  if (!bus.uart_rx_fifo_empty) state_d = S_ACK_CHK;
                   else if (tmo_hit)            state_d = retry_or_fail;
      S_ACK_CHK:   state_d = ack_ok ? (last_b ? S_DONE : S_SEND) : retry_or_fail;
      S_DONE,
      S_FAIL:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q       <= '0;
      data_q     <= '0;
      len_q      <= '0;
      wack_q     <= '0;
      b          <= '0;
      tmo_cnt    <= '0;
      retry_q    <= '0;
      ack_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      echo_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= (state == S_DONE) || (state == S_FAIL);
      tmo_cnt <= in_wait ? tmo_cnt + TW'(1) : '0;
      if (state == S_IDLE) begin
        if (bus.tx_start) begin
          op_q       <= bus.opcode;
          data_q     <= bus.data;
          len_q      <= (bus.data_len > MAX_LEN) ? MAX_LEN : bus.data_len;
          wack_q     <= bus.wait_ack_after;
          b          <= '0;
          retry_q    <= '0;
          ack_err_q  <= 1'b0;
          tmo_err_q  <= 1'b0;
          echo_err_q <= 1'b0;
        end
      end else if (attempt_fail) begin
        if (can_retry) begin
          retry_q <= retry_q + RC_W'(1);
          b       <= '0;
        end else if (state == S_ACK_CHK) begin
          ack_err_q <= 1'b1;
        end else begin
          tmo_err_q <= 1'b1;
        end
      end else if ((state == S_ECHO_CHK) && echo_bad) begin
        echo_err_q <= 1'b1;
      end else if (advance) begin
        b <= b + BW'(1);
      end
    end
  end

  // strobes are gated by reset so an abort never leaks one more FIFO access
  always_comb begin
    bus.tx_ready           = (state == S_IDLE);
    bus.tx_done            = done_q;
    bus.ack_error          = ack_err_q;
    bus.timeout_error      = tmo_err_q;
    bus.echo_error         = echo_err_q;
    bus.retry_count        = retry_q;
    bus.uart_tx_fifo_wr_en = rst && (state == S_SEND) && !bus.uart_tx_fifo_full;
    bus.uart_tx_fifo_data  = (state == S_SEND) ? cur_byte : 8'h00;
    bus.uart_rx_fifo_rd_en = rst && in_wait && !bus.uart_rx_fifo_empty;
  end
endmodule

// File: tb/tb_updi_frame_sequencer.sv
// Directed vectors for the UPDI frame sequencer: no-echo instance with ACK
// handling, timeout and retry, plus an echo instance with RX looped back.
module tb_updi_frame_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  updi_frame_sequencer_if #(.MAX_DATA_SIZE(8), .MAX_RETRIES(1)) ia ();
  updi_frame_sequencer_if #(.MAX_DATA_SIZE(8), .MAX_RETRIES(1)) ib ();

  updi_frame_sequencer #(.MAX_DATA_SIZE(8), .ACK_TIMEOUT_CYCLES(16), .MAX_RETRIES(1),
                         .ECHO_DISCARD(1'b0)) dut_a (.clk(clk), .rst(rst_n), .bus(ia.master));
  updi_frame_sequencer #(.MAX_DATA_SIZE(8), .ACK_TIMEOUT_CYCLES(16), .MAX_RETRIES(1),
                         .ECHO_DISCARD(1'b1)) dut_b (.clk(clk), .rst(rst_n), .bus(ib.master));

  int checks = 0;
  int passes = 0;
  int viol = 0;
  int done_a = 0;
  int done_b = 0;
  int corrupt_at;
  logic [7:0] corrupt_val;
  logic       push_a;
  logic [7:0] push_val;
  logic [7:0] txa[$], txb[$], rxa[$], rxb[$];

  // TX FIFO capture and RX FIFO models; B's RX is fed by its own TX writes
  always @(posedge clk) begin
    if (ia.uart_tx_fifo_wr_en) begin
      if (ia.uart_tx_fifo_full) viol++;
      else txa.push_back(ia.uart_tx_fifo_data);
    end
    if (ia.uart_rx_fifo_rd_en) begin
      if (rxa.size() == 0) viol++;
      else ia.uart_rx_fifo_data <= rxa.pop_front();
    end
    if (push_a) rxa.push_back(push_val);
    if (ia.tx_done) done_a++;
    ia.uart_rx_fifo_empty <= (rxa.size() == 0);

    if (ib.uart_tx_fifo_wr_en) begin
      if (ib.uart_tx_fifo_full) viol++;
      else begin
        rxb.push_back(ib.uart_tx_fifo_data ^ ((txb.size() == corrupt_at) ? corrupt_val : 8'h00));
        txb.push_back(ib.uart_tx_fifo_data);
      end
    end
    if (ib.uart_rx_fifo_rd_en) begin
      if (rxb.size() == 0) viol++;
      else ib.uart_rx_fifo_data <= rxb.pop_front();
    end
    if (ib.tx_done) done_b++;
    ib.uart_rx_fifo_empty <= (rxb.size() == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [3:0]  len;
    logic [63:0] d;      // data[i] at bits i*8
    logic [7:0]  wack;
    int          n_rx;
    logic [15:0] rx;     // bytes queued in RX FIFO before start, first in low byte
    int          full_at;
    int          n_tx;
    logic [79:0] tx;     // expected TX bytes, first in low byte
    logic        to_e;
    logic        ack_e;
    logic [0:0]  rc;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input vec_t v);
    int base, d0, n;
    base = txa.size();
    d0   = done_a;
    for (int i = 0; i < v.n_rx; i++) begin
      @(negedge clk); push_a = 1'b1; push_val = v.rx[i*8 +: 8];
    end
    @(negedge clk); push_a = 1'b0;
    ia.opcode = v.op; ia.data_len = v.len; ia.data = v.d; ia.wait_ack_after = v.wack;
    ia.tx_start = 1'b1;
    @(negedge clk); ia.tx_start = 1'b0;
    chk({v.name, " busy"}, 32'(ia.tx_ready), 32'd0);
    if (v.full_at >= 0) begin
      n = 0;
      while (txa.size() - base < v.full_at && n < 200) begin @(negedge clk); n++; end
      ia.uart_tx_fifo_full = 1'b1;
      repeat (5) @(negedge clk);
      ia.uart_tx_fifo_full = 1'b0;
      chk({v.name, " held"}, 32'(txa.size() - base), 32'(v.full_at));
    end
    n = 0;
    while (ia.tx_done !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk({v.name, " done"}, 32'(n < 500), 32'd1);
    chk({v.name, " ready"}, 32'(ia.tx_ready), 32'd1);
    chk({v.name, " flags"}, {29'd0, ia.timeout_error, ia.ack_error, ia.echo_error},
        {29'd0, v.to_e, v.ack_e, 1'b0});
    chk({v.name, " retry"}, 32'(ia.retry_count), 32'(v.rc));
    repeat (3) @(negedge clk);
    chk({v.name, " pulses"}, 32'(done_a - d0), 32'd1);
    chk({v.name, " count"}, 32'(txa.size() - base), 32'(v.n_tx));
    for (int i = 0; i < v.n_tx; i++)
      chk($sformatf("%s byte%0d", v.name, i), 32'(txa[base + i]), 32'(v.tx[i*8 +: 8]));
    chk({v.name, " rx_empty"}, 32'(ia.uart_rx_fifo_empty), 32'd1);
  endtask

  task automatic run_b(input string nm, input logic [7:0] op, input logic [7:0] cmask,
                       input logic exp_echo);
    int base, d0, n;
    base = txb.size();
    d0   = done_b;
    @(negedge clk);
    corrupt_at  = (cmask != 8'h00) ? base + 1 : -1;
    corrupt_val = cmask;
    ib.opcode = op; ib.data_len = '0; ib.data = '0; ib.wait_ack_after = '0;
    ib.tx_start = 1'b1;
    @(negedge clk); ib.tx_start = 1'b0;
    n = 0;
    while (ib.tx_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk({nm, " done"}, 32'(n < 200), 32'd1);
    chk({nm, " flags"}, {29'd0, ib.timeout_error, ib.ack_error, ib.echo_error},
        {31'd0, exp_echo});
    chk({nm, " retry"}, 32'(ib.retry_count), 32'd0);
    repeat (3) @(negedge clk);
    chk({nm, " pulses"}, 32'(done_b - d0), 32'd1);
    chk({nm, " count"}, 32'(txb.size() - base), 32'd2);
    chk({nm, " sync"}, 32'(txb[base]), 32'h55);
    chk({nm, " opcode"}, 32'(txb[base + 1]), 32'(op));
    chk({nm, " rx_empty"}, 32'(ib.uart_rx_fifo_empty), 32'd1);
  endtask

  initial begin
    int base, n;
    rst_n = 1'b0; push_a = 1'b0; push_val = 8'h00; corrupt_at = -1; corrupt_val = 8'h00;
    ia.tx_start = 1'b0; ia.uart_tx_fifo_full = 1'b0; ia.opcode = '0; ia.data = '0;
    ia.data_len = '0; ia.wait_ack_after = '0;
    ib.tx_start = 1'b0; ib.uart_tx_fifo_full = 1'b0; ib.opcode = '0; ib.data = '0;
    ib.data_len = '0; ib.wait_ack_after = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(ia.tx_ready), 32'd1);
    chk("rst strobes", {29'd0, ia.tx_done, ia.uart_tx_fifo_wr_en, ia.uart_rx_fifo_rd_en}, 32'd0);
    chk("rst flags", {28'd0, ia.retry_count, ia.timeout_error, ia.ack_error, ia.echo_error}, 32'd0);
    chk("rst txdata", 32'(ia.uart_tx_fifo_data), 32'd0);
    chk("rst b ready", 32'(ib.tx_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    vt[0] = '{"ack2", 8'h45, 4'd4, 64'h78563412, 8'h0A, 2, 16'h4040, -1,
              6, 80'h785634124555, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"tmo", 8'h45, 4'd2, 64'h3412, 8'h02, 0, 16'h0000, -1,
              8, 80'h3412455534124555, 1'b1, 1'b0, 1'b1};
    vt[2] = '{"retry_ok", 8'h45, 4'd2, 64'h3412, 8'h02, 2, 16'h4000, -1,
              8, 80'h3412455534124555, 1'b0, 1'b0, 1'b1};
    vt[3] = '{"full", 8'h45, 4'd4, 64'h78563412, 8'h00, 0, 16'h0000, 3,
              6, 80'h785634124555, 1'b0, 1'b0, 1'b0};
    vt[4] = '{"len0", 8'h20, 4'd0, 64'h0, 8'hFF, 0, 16'h0000, -1,
              2, 80'h2055, 1'b0, 1'b0, 1'b0};
    vt[5] = '{"clamp", 8'h45, 4'd12, 64'h0807060504030201, 8'h00, 0, 16'h0000, -1,
              10, 80'h0807060504030201_4555, 1'b0, 1'b0, 1'b0};
    vt[6] = '{"nak", 8'h45, 4'd1, 64'h12, 8'h01, 2, 16'h0000, -1,
              6, 80'h124555124555, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) run_vec(vt[k]);

    run_b("echo_ok", 8'h04, 8'h00, 1'b0);
    run_b("echo_bad", 8'h04, 8'h01, 1'b1);

    // reset in the middle of a frame
    base = txa.size();
    @(negedge clk);
    ia.opcode = 8'h45; ia.data_len = 4'd4; ia.data = 64'h78563412; ia.wait_ack_after = '0;
    ia.tx_start = 1'b1;
    @(negedge clk); ia.tx_start = 1'b0;
    n = 0;
    while (txa.size() - base < 3 && n < 50) begin @(negedge clk); n++; end
    chk("abort 3 sent", 32'(txa.size() - base), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort ready", 32'(ia.tx_ready), 32'd1);
    chk("abort strobes", {29'd0, ia.tx_done, ia.uart_tx_fifo_wr_en, ia.uart_rx_fifo_rd_en}, 32'd0);
    chk("abort txdata", 32'(ia.uart_tx_fifo_data), 32'd0);
    chk("abort flags", {28'd0, ia.retry_count, ia.timeout_error, ia.ack_error, ia.echo_error}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort no writes", 32'(txa.size() - base), 32'd3);
    chk("abort idle", 32'(ia.tx_ready), 32'd1);

    chk("fifo protocol", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
